// File: rtl/or_cnt_pkg.sv
// Shared types and defaults for the OR channel pulse counter.
// Holds the FSM state encoding and the window counter width.
package or_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_HOLD
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int GATE_CYCLES_DEF = 1000;
    localparam int WIN_W           = 24;

endpackage

// File: rtl/pulse_edge_sync.sv
// Three-flop synchronizer for an asynchronous pulse line.
// RISE is a one-cycle strobe for each synchronized rising edge.
module pulse_edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic CH_IN,
    output logic RISE
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= CH_IN;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign RISE = s2_q & ~s3_q;

endmodule

// File: rtl/or_channel_counter.sv
// Gated pulse counter for the combined OR channel, result via VALID/READY.
// Define OR_CNT_CONTINUOUS_EN to re-arm the window on every handshake.
module or_channel_counter
    import or_cnt_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CH_IN,
    input  logic             START,
    output logic             BUSY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF,
    output logic             VALID,
    input  logic             READY
);

    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX  = '1;

    logic rise;

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               oacc_q, oacc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   acc_inc;
    logic               oacc_inc;

    pulse_edge_sync u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .CH_IN (CH_IN),
        .RISE  (rise)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            acc_q   <= '0;
            oacc_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
            oacc_q  <= oacc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        acc_d    = acc_q;
        oacc_d   = oacc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        acc_inc  = acc_q;
        oacc_inc = oacc_q;

        // Saturating increment; a lost increment flags overflow
        if (rise) begin
            if (acc_q == ACC_MAX) begin
                oacc_inc = 1'b1;
            end else begin
                acc_inc = acc_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    acc_d   = '0;
                    oacc_d  = 1'b0;
                    win_d   = WIN_LOAD;
                    state_d = ST_GATE;
                end
            end
            ST_GATE: begin
                acc_d  = acc_inc;
                oacc_d = oacc_inc;
                if (win_q == '0) begin
                    count_d = acc_inc;
                    ovf_d   = oacc_inc;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (READY) begin
                    valid_d = 1'b0;
`ifdef OR_CNT_CONTINUOUS_EN
                    acc_d   = '0;
                    oacc_d  = 1'b0;
                    win_d   = WIN_LOAD;
                    state_d = ST_GATE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY  = (state_q != ST_IDLE);
    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_or_channel_counter.sv
// Scoreboard bench for or_channel_counter (CNT_W=4, GATE_CYCLES=100).
// Build with OR_CNT_CONTINUOUS_EN to exercise the continuous-window mode.
module tb_or_channel_counter;

    localparam int CW = 4;
    localparam int G  = 100;

    logic          CLK   = 1'b0;
    logic          RST   = 1'b1;
    logic          CH_IN = 1'b0;
    logic          START = 1'b0;
    logic          READY = 1'b0;
    logic          BUSY;
    logic          OVF;
    logic          VALID;
    logic [CW-1:0] COUNT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int count;
        int ovf;
        int at;
        int tol;
    } exp_t;

    exp_t sb[$];

    or_channel_counter #(
        .CNT_W       (CW),
        .GATE_CYCLES (G)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .CH_IN (CH_IN),
        .START (START),
        .BUSY  (BUSY),
        .COUNT (COUNT),
        .OVF   (OVF),
        .VALID (VALID),
        .READY (READY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(string nm, int act, int exp, int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d",
                     nm, act, exp, tol);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulses(int n, int hi, int lo);
        repeat (n) begin
            CH_IN = 1'b1;
            step(hi);
            CH_IN = 1'b0;
            step(lo);
        end
    endtask

    task automatic start_win(output int sc);
        START = 1'b1;
        step(1);
        START = 1'b0;
        sc = cyc;
    endtask

    task automatic expect_res(int at, int c, int o, int tol);
        exp_t e;
        e.count = c;
        e.ovf   = o;
        e.at    = at;
        e.tol   = tol;
        sb.push_back(e);
    endtask

    task automatic wait_valid(string nm);
        int n = 0;
        while (!VALID && n < 400) begin
            step(1);
            n++;
        end
        chk({nm, "_valid_timeout"}, int'(n < 400), 1);
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while ((BUSY || VALID) && n < 400) begin
            step(1);
            n++;
        end
        chk({nm, "_idle_timeout"}, int'(n < 400), 1);
    endtask

    task automatic monitor();
        logic vp = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                vp = 1'b0;
            end else begin
                if (VALID && !vp) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk_rng("sb_count", int'(COUNT), e.count, e.tol);
                        chk("sb_ovf", int'(OVF), e.ovf);
                        chk("sb_valid_cycle", cyc, e.at);
                    end
                end
                vp = VALID;
            end
        end
    endtask

    initial begin
        int sc;
        fork
            monitor();
        join_none

        step(3);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_valid", int'(VALID), 0);
        chk("rst_count", int'(COUNT), 0);
        chk("rst_ovf", int'(OVF), 0);
        RST = 1'b0;
        step(2);
        chk("post_rst_busy", int'(BUSY), 0);

`ifdef OR_CNT_CONTINUOUS_EN
        READY = 1'b1;
        start_win(sc);
        for (int k = 0; k < 3; k++) begin
            expect_res(sc + G + k * (G + 1), 10, 0, 1);
        end
        pulses(31, 1, 9);
        chk("cont_busy", int'(BUSY), 1);
        RST = 1'b1;
        step(2);
        chk("cont_rst_busy", int'(BUSY), 0);
`else
        // Reset 40 cycles into a window discards everything
        start_win(sc);
        pulses(5, 2, 3);
        step(15);
        RST = 1'b1;
        #1;
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_valid", int'(VALID), 0);
        chk("midrst_count", int'(COUNT), 0);
        chk("midrst_ovf", int'(OVF), 0);
        step(2);
        RST = 1'b0;
        step(120);
        chk("midrst_idle", int'(BUSY), 0);

        READY = 1'b1;
        start_win(sc);
        expect_res(sc + G, 10, 0, 0);
        pulses(10, 2, 3);
        wait_valid("basic");
        step(1);
        chk("basic_valid_1cyc", int'(VALID), 0);
        wait_idle("basic");

        // Rise in the last GATE cycle is counted
        start_win(sc);
        expect_res(sc + G, 2, 0, 0);
        pulses(1, 2, 3);
        step(G - 8);
        CH_IN = 1'b1;
        step(2);
        CH_IN = 1'b0;
        wait_idle("bnd_last");

        // Rise one cycle later lands in HOLD
        start_win(sc);
        expect_res(sc + G, 1, 0, 0);
        pulses(1, 2, 3);
        step(G - 7);
        CH_IN = 1'b1;
        step(2);
        CH_IN = 1'b0;
        wait_idle("bnd_late");

        start_win(sc);
        expect_res(sc + G, 15, 1, 0);
        pulses(20, 2, 3);
        wait_idle("sat");
        start_win(sc);
        expect_res(sc + G, 3, 0, 0);
        pulses(3, 2, 3);
        wait_idle("sat_next");

        READY = 1'b0;
        start_win(sc);
        expect_res(sc + G, 4, 0, 0);
        pulses(4, 2, 3);
        wait_valid("bp");
        for (int i = 0; i < 50; i++) begin
            CH_IN = ((i % 2) == 1);
            START = (i == 10);
            step(1);
            chk("bp_valid_held", int'(VALID), 1);
            chk("bp_count_stable", int'(COUNT), 4);
        end
        CH_IN = 1'b0;
        START = 1'b0;
        READY = 1'b1;
        step(1);
        chk("bp_done_busy", int'(BUSY), 0);
        chk("bp_done_valid", int'(VALID), 0);
        step(5);
        chk("bp_start_not_queued", int'(BUSY), 0);
`endif

        step(2);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
